clkdiv_ctrl: RTL and testbench

- Run-time controller for the board clock divider.
- Owns a half-period counter and square-wave output `clkout`. Divider semantics: toggle when count reaches the divide value, so a half-period is `div+1` cycles.
- Adds a glitch-free divide-value reload via a req/ack handshake, a clean enable/stop sequence and a one-cycle `tick` strobe.
- Sits between the control logic (buttons/FSMs) and the LED/display timing consumers.

---
 rtl/clkdiv_ctrl.sv | 118 +++++++++++
 tb/tb_clkdiv_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ctrl.sv
// clkdiv_ctrl: run-time clock divider with glitch-free divide reload,
// clean enable/stop sequencing and a post-toggle tick strobe.
module clkdiv_ctrl #(
    parameter int               CNT_W       = 32,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(25000000)
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_req,
    output logic             div_ack,
    output logic             clkout,
    output logic             tick,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_cur_div;
    logic [CNT_W-1:0] r_pend_div;
    logic             r_pend_valid;
    logic             r_div_ack;
    logic             r_clkout;
    logic             r_tick;
    logic             r_busy;

    logic             w_bnd;
    logic             w_step;
    logic             w_accept;
    logic             w_apply;

    assign w_bnd    = (r_cnt == r_cur_div);
    // DRAIN keeps counting only while a high phase must be completed
    assign w_step   = (r_state == S_RUN) ||
                      ((r_state == S_DRAIN) && (en || r_clkout));
    assign w_accept = div_req && !r_pend_valid && !r_div_ack;
    assign w_apply  = r_pend_valid &&
                      ((w_step && w_bnd) || (r_state == S_IDLE));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_cur_div    <= DEFAULT_DIV;
            r_pend_div   <= '0;
            r_pend_valid <= 1'b0;
            r_div_ack    <= 1'b0;
            r_clkout     <= 1'b0;
            r_tick       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_div_ack <= w_accept;
            if (w_accept) begin
                r_pend_div   <= div_val;
                r_pend_valid <= 1'b1;
            end else if (w_apply) begin
                r_cur_div    <= r_pend_div;
                r_pend_valid <= 1'b0;
            end

            if (w_step) begin
                if (w_bnd) begin
                    r_cnt    <= '0;
                    r_clkout <= ~r_clkout;
                    r_tick   <= 1'b1;
                end else begin
                    r_cnt    <= r_cnt + CNT_W'(1);
                    r_tick   <= 1'b0;
                end
            end else begin
                r_cnt    <= '0;
                r_clkout <= 1'b0;
                r_tick   <= 1'b0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (en) begin
                        r_state <= S_RUN;
                    end else if (!r_clkout || w_bnd) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign div_ack = r_div_ack;
    assign clkout  = r_clkout;
    assign tick    = r_tick;
    assign busy    = r_busy;
    assign cur_div = r_cur_div;

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// tb_clkdiv_ctrl: directed stimulus, per-cycle half-period model
// plus literal edge-spacing and handshake expectations.
module tb_clkdiv_ctrl;

    localparam logic [31:0] DEF = 32'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [31:0] div_val;
    logic        div_req;
    logic        div_ack;
    logic        clkout;
    logic        tick;
    logic        busy;
    logic [31:0] cur_div;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int edges[$];
    logic prev_out = 1'b0;

    // model: half-period as a down-counter of remaining cycles
    int          m_mode;
    logic [31:0] m_cur;
    longint      m_left;
    bit          m_out;
    bit          m_tick;
    bit          m_ack;
    bit          m_had;
    bit          m_acc;
    bit          m_go;
    bit          m_last;
    logic [31:0] m_q[$];

    clkdiv_ctrl #(
        .CNT_W(32),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clkin(clk),
        .rst_n(rst_n),
        .en(en),
        .div_val(div_val),
        .div_req(div_req),
        .div_ack(div_ack),
        .clkout(clkout),
        .tick(tick),
        .busy(busy),
        .cur_div(cur_div)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (clkout !== prev_out) begin
            edges.push_back(cyc);
            prev_out = clkout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int gap(input int k);
        int n;
        n = edges.size();
        if (n < k + 2) return -1;
        return edges[n-1-k] - edges[n-2-k];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0;
            m_cur  = DEF;
            m_left = longint'(DEF) + 1;
            m_out  = 1'b0;
            m_tick = 1'b0;
            m_ack  = 1'b0;
            m_q.delete();
        end else begin
            m_had  = (m_q.size() != 0);
            m_acc  = div_req && !m_had && !m_ack;
            m_last = 1'b0;
            if (m_mode == 0) begin
                m_out  = 1'b0;
                m_tick = 1'b0;
                if (m_had) m_cur = m_q.pop_front();
                m_left = longint'(m_cur) + 1;
                if (en) m_mode = 1;
            end else begin
                m_go = (m_mode == 1) || en || m_out;
                if (!m_go) begin
                    m_mode = 0;
                    m_tick = 1'b0;
                    m_left = longint'(m_cur) + 1;
                end else begin
                    m_left = m_left - 1;
                    m_last = (m_left == 0);
                    m_tick = m_last;
                    if (m_last) begin
                        m_out = !m_out;
                        if (m_had) m_cur = m_q.pop_front();
                        m_left = longint'(m_cur) + 1;
                    end
                    if (m_mode == 1 && !en) m_mode = 2;
                    else if (m_mode == 2 && en) m_mode = 1;
                    else if (m_mode == 2 && m_last) m_mode = 0;
                end
            end
            if (m_acc) m_q.push_back(div_val);
            m_ack = m_acc;
        end
    end

    always @(negedge clk) begin
        chk("m_clkout", 32'(clkout), 32'(m_out));
        chk("m_tick", 32'(tick), 32'(m_tick));
        chk("m_busy", 32'(busy), 32'(m_mode != 0));
        chk("m_ack", 32'(div_ack), 32'(m_ack));
        chk("m_cur_div", cur_div, m_cur);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int t;
        int n;
        int ne;
        logic pv;
        rst_n   = 1'b1;
        en      = 1'b0;
        div_req = 1'b0;
        div_val = '0;
        #1 rst_n = 1'b0;
        step(3);
        chk("rst_clkout", 32'(clkout), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(div_ack), 0);
        chk("rst_cur_div", cur_div, 3);
        rst_n = 1'b1;
        step(2);

        t  = cyc;
        en = 1'b1;
        step(14);
        chk("t1_nedges", 32'(edges.size()), 3);
        chk("t1_first", 32'(edges[0] - t), 5);
        chk("t1_gap_a", 32'(gap(1)), 4);
        chk("t1_gap_b", 32'(gap(0)), 4);
        chk("t1_busy", 32'(busy), 1);
        chk("t1_clkout", 32'(clkout), 1);

        div_req = 1'b1;
        div_val = 32'd1;
        step(1);
        chk("t2_ack", 32'(div_ack), 1);
        div_req = 1'b0;
        step(2);
        chk("t2_cur_div", cur_div, 1);
        chk("t2_gap_old", 32'(gap(0)), 4);
        step(4);
        chk("t2_gap_a", 32'(gap(1)), 2);
        chk("t2_gap_b", 32'(gap(0)), 2);

        step(1);
        div_req = 1'b1;
        div_val = 32'd3;
        step(1);
        chk("t3_ack_a", 32'(div_ack), 1);
        div_req = 1'b0;
        step(1);
        div_req = 1'b1;
        div_val = 32'd5;
        n = 0;
        do begin
            step(1);
            n++;
        end while (div_ack !== 1'b1 && n < 10);
        chk("t3_ack_wait", 32'(n), 2);
        div_req = 1'b0;
        chk("t3_cur_div3", cur_div, 3);
        step(9);
        chk("t3_gap6", 32'(gap(0)), 6);
        chk("t3_gap4", 32'(gap(1)), 4);
        chk("t3_gap2", 32'(gap(2)), 2);
        chk("t3_cur_div5", cur_div, 5);

        div_req = 1'b1;
        div_val = 32'd3;
        step(1);
        chk("t4_ack", 32'(div_ack), 1);
        div_req = 1'b0;
        step(5);
        chk("t4_pre_gap", 32'(gap(0)), 6);
        chk("t4_pre_clk", 32'(clkout), 1);
        en = 1'b0;
        step(4);
        chk("t4_drain_gap", 32'(gap(0)), 4);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_clkout", 32'(clkout), 0);
        chk("t4_tick", 32'(tick), 1);
        en = 1'b1;
        t  = cyc;
        step(9);
        chk("t4_restart", 32'(edges[edges.size()-2] - t), 5);
        chk("t4_gap", 32'(gap(0)), 4);
        en = 1'b0;
        ne = edges.size();
        step(3);
        chk("t4_low_busy", 32'(busy), 0);
        chk("t4_no_edge", 32'(edges.size() - ne), 0);

        en = 1'b1;
        step(5);
        chk("t5_clk_hi", 32'(clkout), 1);
        step(1);
        en = 1'b0;
        step(1);
        chk("t5_drain_busy", 32'(busy), 1);
        en = 1'b1;
        ne = edges.size();
        step(6);
        chk("t5_nedges", 32'(edges.size() - ne), 2);
        chk("t5_gap_a", 32'(gap(1)), 4);
        chk("t5_gap_b", 32'(gap(0)), 4);
        chk("t5_clkout", 32'(clkout), 1);

        en = 1'b0;
        step(6);
        chk("t6_idle", 32'(busy), 0);
        chk("t6_idle_clk", 32'(clkout), 0);
        div_req = 1'b1;
        div_val = 32'd0;
        step(1);
        chk("t6_ack", 32'(div_ack), 1);
        div_req = 1'b0;
        step(1);
        chk("t6_cur_div", cur_div, 0);
        en = 1'b1;
        step(2);
        chk("t6_tick0", 32'(tick), 1);
        for (int i = 0; i < 6; i++) begin
            pv = clkout;
            step(1);
            chk("t6_tick", 32'(tick), 1);
            chk("t6_toggle", 32'(clkout), 32'(!pv));
        end
        rst_n = 1'b0;
        #1;
        chk("arst_clkout", 32'(clkout), 0);
        chk("arst_tick", 32'(tick), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cur_div", cur_div, 3);
        step(2);
        rst_n = 1'b1;
        en    = 1'b0;
        step(3);
        chk("post_busy", 32'(busy), 0);
        chk("post_cur_div", cur_div, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
